// File: rtl/des_f_serial.sv
// Serial DES round function: f(R,K) = P(S(E(R) xor K)), with one shared S-box
// path that handles one 6-bit chunk per cycle, so each result takes 8 cycles.
//   state | meaning
//   IDLE  | waiting for start; f_out holds the last result
//   SUB   | one S-box lookup per cycle, cnt selects the chunk and the S-box
module des_f_serial (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [31:0] r_in,
   input  logic [47:0] subkey,
   output logic        busy,
   output logic        done,
   output logic [31:0] f_out
);

   typedef enum logic {IDLE, SUB} state_t;

   // Each table is row-major: entry (row*16 + col), row 0 column 0 in the top nibble.
   localparam logic [255:0] S_TAB [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   function automatic logic [47:0] e_exp(input logic [31:0] r);
      return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
              r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] v);
      return {v[16], v[25], v[12], v[11], v[3],  v[20], v[4],  v[15],
              v[31], v[17], v[9],  v[6],  v[27], v[14], v[1],  v[22],
              v[30], v[24], v[8],  v[18], v[0],  v[5],  v[29], v[23],
              v[13], v[19], v[2],  v[26], v[10], v[21], v[28], v[7]};
   endfunction

   function automatic logic [3:0] s_lookup(input logic [2:0] n, input logic [5:0] c);
      logic [5:0]   idx;
      logic [255:0] t;
      idx = {c[5], c[0], c[4:1]};
      t   = S_TAB[n] << {idx, 2'b00};
      return t[255:252];
   endfunction

   state_t      state;
   logic [47:0] x;
   logic [2:0]  cnt;
   logic [31:0] acc;
   logic [5:0]  base;
   logic [5:0]  chunk;
   logic [3:0]  nibble;
   logic [31:0] acc_next;

   always_comb begin
      base     = 6'd47 - 6'd6 * {3'd0, cnt};
      chunk    = x[base -: 6];
      nibble   = s_lookup(cnt, chunk);
      acc_next = {acc[27:0], nibble};
   end

   assign busy = (state == SUB);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= IDLE;
         x     <= '0;
         cnt   <= '0;
         acc   <= '0;
         done  <= 1'b0;
         f_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x     <= e_exp(r_in) ^ subkey;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= SUB;
               end
            end
            SUB: begin
               acc <= acc_next;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  f_out <= p_perm(acc_next);
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
